// File: rtl/alu_pkg.sv
// Shared ALU definitions: sign-unit op encodings and the iterative FSM state type.
package alu_pkg;

    localparam logic [1:0] OP_PASS = 2'b00;
    localparam logic [1:0] OP_NEG  = 2'b01;
    localparam logic [1:0] OP_ABS  = 2'b10;
    localparam logic [1:0] OP_NABS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/negate_iter_inc_chunk.sv
// One CHUNK-wide slice of the two's-complement datapath: optional invert, then +carry.
module inc_chunk #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] d_i,
    input  logic             inv_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o
);

    logic [CHUNK-1:0] opnd;

    // Conditional invert followed by a carry-in increment with carry-out.
    always_comb begin
        opnd            = inv_i ? ~d_i : d_i;
        {cout_o, sum_o} = (CHUNK + 1)'(opnd) + (CHUNK + 1)'(cin_i);
    end

endmodule

// File: rtl/negate_iter.sv
// Multi-cycle pass/negate/abs/nabs unit; one CHUNK per BUSY cycle, carry rippled in a register.
module negate_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [KW-1:0]    K_LAST   = KW'(NCHUNK - 1);

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d;
    logic             inv_q, inv_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [CHUNK-1:0] chunk_in;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic             inv_acc;

    assign chunk_in = a_q[int'(k_q) * CHUNK +: CHUNK];

    // Invert decision for the operand presented on the accepting edge.
    assign inv_acc = (op == OP_NEG)
                   | ((op == OP_ABS)  &  a[WIDTH-1])
                   | ((op == OP_NABS) & ~a[WIDTH-1]);

    inc_chunk #(.CHUNK(CHUNK)) u_inc (
        .d_i    (chunk_in),
        .inv_i  (inv_q),
        .cin_i  (carry_q),
        .sum_o  (chunk_sum),
        .cout_o (chunk_cout)
    );

    // Next-state, datapath update and registered-output decode.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        carry_d  = carry_q;
        inv_d    = inv_q;
        a_d      = a_q;
        op_d     = op_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_BUSY;
                    a_d      = a;
                    op_d     = op;
                    inv_d    = inv_acc;
                    carry_d  = inv_acc;
                    k_d      = '0;
                    result_d = '0;
                    ovf_d    = 1'b0;
                    busy_d   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                result_d[int'(k_q) * CHUNK +: CHUNK] = chunk_sum;
                carry_d = chunk_cout;
                if (k_q == K_LAST) begin
                    state_d = ST_DONE;
                    k_d     = '0;
                    done_d  = 1'b1;
                    ovf_d   = ((op_q == OP_NEG) || (op_q == OP_ABS)) && (a_q == MOST_NEG);
                end else begin
                    k_d    = k_q + KW'(1);
                    busy_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; clear wins over everything.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            carry_q  <= 1'b0;
            inv_q    <= 1'b0;
            a_q      <= '0;
            op_q     <= OP_PASS;
            result_q <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            carry_q  <= carry_d;
            inv_q    <= inv_d;
            a_q      <= a_d;
            op_q     <= op_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_negate_iter.sv
// Directed and swept checks of negate_iter: vector table, handshake corners, parameter sweep.
module tb_negate_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clear;

    // Main instance, 32/8
    logic        m_start;
    logic [1:0]  m_op;
    logic [31:0] m_a;
    logic        m_busy, m_done, m_ovf;
    logic [31:0] m_res;

    // Sweep instances
    logic        sw_start;
    logic [1:0]  sw_op;
    logic [15:0] sw_a16;
    logic [31:0] sw_a32;
    logic [63:0] sw_a64;
    logic        b0, d0, o0, b1, d1, o1, b2, d2, o2;
    logic [15:0] r0;
    logic [31:0] r1;
    logic [63:0] r2;

    int n_checks = 0;
    int n_fail   = 0;

    negate_iter #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .clear(clear), .start(m_start), .op(m_op), .a(m_a),
        .busy(m_busy), .done(m_done), .result(m_res), .overflow(m_ovf));

    negate_iter #(.WIDTH(16), .CHUNK(4)) dut_16_4 (
        .clk(clk), .clear(clear), .start(sw_start), .op(sw_op), .a(sw_a16),
        .busy(b0), .done(d0), .result(r0), .overflow(o0));

    negate_iter #(.WIDTH(32), .CHUNK(32)) dut_32_32 (
        .clk(clk), .clear(clear), .start(sw_start), .op(sw_op), .a(sw_a32),
        .busy(b1), .done(d1), .result(r1), .overflow(o1));

    negate_iter #(.WIDTH(64), .CHUNK(16)) dut_64_16 (
        .clk(clk), .clear(clear), .start(sw_start), .op(sw_op), .a(sw_a64),
        .busy(b2), .done(d2), .result(r2), .overflow(o2));

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] exp_res;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Golden model: returns {overflow, result} for a width-w operand.
    function automatic logic [64:0] model(input logic [63:0] av, input logic [1:0] o, input int w);
        logic [63:0] mask, r, x;
        logic        msb, inv, ovf;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        x    = av & mask;
        msb  = x[w-1];
        inv  = (o == 2'b01) || (o == 2'b10 && msb) || (o == 2'b11 && !msb);
        r    = inv ? ((~x + 64'd1) & mask) : x;
        ovf  = ((o == 2'b01) || (o == 2'b10)) && (x == (64'd1 << (w - 1)));
        return {ovf, r};
    endfunction

    // Present one request on the main instance; returns at the negedge after the accepting edge.
    task automatic start_main(input logic [1:0] o, input logic [31:0] av);
        @(negedge clk);
        m_start = 1'b1;
        m_op    = o;
        m_a     = av;
        @(negedge clk);
        m_start = 1'b0;
    endtask

    // Wait for done on the main instance, counting edges and busy cycles.
    task automatic wait_main(output int lat, output int busy_cnt, output bit both);
        lat = 0; busy_cnt = 0; both = 1'b0;
        while (!m_done && lat < 40) begin
            if (m_busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        if (m_busy && m_done) both = 1'b1;
        if (!m_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_done: timeout, done=%0b required 1", m_done);
        end
    endtask

    initial begin
        int lat, bcnt;
        bit both;
        logic [63:0] ra16, ra32, ra64;
        logic [1:0]  rop;
        int l0, l1, l2;
        bit s0, s1, s2;
        int cyc;

        vecs[0] = '{2'b01, 32'h0000_0005, 32'hFFFF_FFFB, 1'b0};
        vecs[1] = '{2'b01, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[2] = '{2'b10, 32'hFFFF_FF9C, 32'h0000_0064, 1'b0};
        vecs[3] = '{2'b10, 32'h0000_0064, 32'h0000_0064, 1'b0};
        vecs[4] = '{2'b11, 32'h0000_0064, 32'hFFFF_FF9C, 1'b0};
        vecs[5] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 1'b1};
        vecs[6] = '{2'b11, 32'h8000_0000, 32'h8000_0000, 1'b0};
        vecs[7] = '{2'b00, 32'h1234_5678, 32'h1234_5678, 1'b0};
        vecs[8] = '{2'b10, 32'h8000_0000, 32'h8000_0000, 1'b1};
        vecs[9] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};

        clear = 1'b1; m_start = 1'b0; m_op = 2'b00; m_a = '0;
        sw_start = 1'b0; sw_op = 2'b00; sw_a16 = '0; sw_a32 = '0; sw_a64 = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 65'(m_busy), 65'(0));
        check("reset_done", 65'(m_done), 65'(0));
        check("reset_result", 65'(m_res), 65'(0));
        check("reset_ovf", 65'(m_ovf), 65'(0));
        clear = 1'b0;

        // Vector table
        for (int i = 0; i < 10; i++) begin
            start_main(vecs[i].op, vecs[i].a);
            check($sformatf("v%0d_cleared", i), 65'(m_res), 65'(0));
            wait_main(lat, bcnt, both);
            check($sformatf("v%0d_latency", i), 65'(lat), 65'(4));
            check($sformatf("v%0d_busycnt", i), 65'(bcnt), 65'(4));
            check($sformatf("v%0d_busy_done_overlap", i), 65'(both), 65'(0));
            check($sformatf("v%0d_result", i), 65'(m_res), 65'(vecs[i].exp_res));
            check($sformatf("v%0d_ovf", i), 65'(m_ovf), 65'(vecs[i].exp_ovf));
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), 65'(m_done), 65'(0));
            check($sformatf("v%0d_held", i), 65'(m_res), 65'(vecs[i].exp_res));
        end

        // start while busy is ignored
        start_main(2'b01, 32'd7);
        m_start = 1'b1; m_op = 2'b00; m_a = 32'd9;
        @(negedge clk);
        m_start = 1'b0;
        wait_main(lat, bcnt, both);
        check("ignore_latency", 65'(lat), 65'(3));
        check("ignore_result", 65'(m_res), 65'(32'hFFFF_FFF9));

        // back-to-back start during DONE
        start_main(2'b01, 32'd7);
        wait_main(lat, bcnt, both);
        check("b2b_first_result", 65'(m_res), 65'(32'hFFFF_FFF9));
        m_start = 1'b1; m_op = 2'b01; m_a = 32'd3;
        @(negedge clk);
        m_start = 1'b0;
        check("b2b_busy", 65'(m_busy), 65'(1));
        check("b2b_done", 65'(m_done), 65'(0));
        wait_main(lat, bcnt, both);
        check("b2b_latency", 65'(lat), 65'(4));
        check("b2b_result", 65'(m_res), 65'(32'hFFFF_FFFD));

        // clear during the second BUSY cycle
        start_main(2'b01, 32'h1234_5678);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_busy", 65'(m_busy), 65'(0));
        check("clr_done", 65'(m_done), 65'(0));
        check("clr_result", 65'(m_res), 65'(0));
        check("clr_ovf", 65'(m_ovf), 65'(0));
        repeat (5) @(negedge clk);
        check("clr_stays_idle", 65'({m_busy, m_done}), 65'(0));
        start_main(2'b01, 32'd1);
        wait_main(lat, bcnt, both);
        check("clr_after_latency", 65'(lat), 65'(4));
        check("clr_after_result", 65'(m_res), 65'(32'hFFFF_FFFF));

        // Parameter sweep
        for (int it = 0; it < 1000; it++) begin
            rop  = 2'($urandom_range(0, 3));
            ra16 = 64'($urandom);
            ra32 = 64'($urandom);
            ra64 = {32'($urandom), 32'($urandom)};
            case ($urandom_range(0, 7))
                0: begin ra16 = 64'h8000; ra32 = 64'h8000_0000; ra64 = 64'h8000_0000_0000_0000; end
                1: begin ra16 = 64'h0; ra32 = 64'h0; ra64 = 64'h0; end
                default: ;
            endcase
            @(negedge clk);
            sw_start = 1'b1; sw_op = rop;
            sw_a16 = ra16[15:0]; sw_a32 = ra32[31:0]; sw_a64 = ra64;
            @(negedge clk);
            sw_start = 1'b0;
            l0 = -1; l1 = -1; l2 = -1; s0 = 1'b0; s1 = 1'b0; s2 = 1'b0;
            cyc = 0;
            while (!(s0 && s1 && s2) && cyc < 20) begin
                @(negedge clk);
                cyc++;
                if (!s0 && d0) begin s0 = 1'b1; l0 = cyc; end
                if (!s1 && d1) begin s1 = 1'b1; l1 = cyc; end
                if (!s2 && d2) begin s2 = 1'b1; l2 = cyc; end
            end
            check($sformatf("sw16_%0d_lat", it), 65'(l0), 65'(4));
            check($sformatf("sw32_%0d_lat", it), 65'(l1), 65'(1));
            check($sformatf("sw64_%0d_lat", it), 65'(l2), 65'(4));
            check($sformatf("sw16_%0d_res op=%0d a=%0h", it, rop, ra16[15:0]),
                  {o0, 48'h0, r0}, model(ra16, rop, 16));
            check($sformatf("sw32_%0d_res op=%0d a=%0h", it, rop, ra32[31:0]),
                  {o1, 32'h0, r1}, model(ra32, rop, 32));
            check($sformatf("sw64_%0d_res op=%0d a=%0h", it, rop, ra64),
                  {o2, r2}, model(ra64, rop, 64));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
